// File: rtl/fpu_cfg_pkg.sv
// Shared definitions for the FPU configuration loader: register map,
// loader states, error codes and filter word sizing.
package fpu_cfg_pkg;

    localparam logic [31:0] OFF_DIMS     = 32'h000;
    localparam logic [31:0] OFF_START    = 32'h020;
    localparam logic [31:0] OFF_FILTER   = 32'h040;
    localparam logic [31:0] OFF_RESULT   = 32'h100;
    localparam logic [31:0] OFF_STARTSIG = 32'h120;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_ZERO_DIM = 2'd2;
    localparam logic [1:0] ERR_WIDTH    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_LOAD,
        ST_CHECK,
        ST_ACTIVE,
        ST_RELEASE,
        ST_REL_GAP
    } state_e;

    // Four signed coefficients are packed per 32-bit word.
    function automatic int filter_word_count(input int k);
        return (k * k + 3) / 4;
    endfunction

endpackage

// File: rtl/fpu_config_loader_if.sv
// Mapped-memory read bus between the configuration loader and the
// register window.
interface fpu_config_loader_if;
    logic [31:0] address_mem;
    logic        rd_req_mem;
    logic [31:0] data_mem;
    logic        mapped_data_valid;

    modport master (
        output address_mem,
        output rd_req_mem,
        input  data_mem,
        input  mapped_data_valid
    );

    modport slave (
        input  address_mem,
        input  rd_req_mem,
        output data_mem,
        output mapped_data_valid
    );
endinterface

// File: rtl/fpu_mmio_reader.sv
// Single outstanding mapped-memory read with a response timeout.
// rd_done / rd_timeout are same-cycle indications; the request drops on the next edge.
module fpu_mmio_reader #(
    parameter logic [31:0] RESET_ADDR = 32'h1000_0120,
    parameter int          TIMEOUT    = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_start,
    input  logic [31:0]                rd_addr,
    fpu_config_loader_if.master        mem,
    output logic [31:0]                rd_data,
    output logic                       rd_done,
    output logic                       rd_timeout,
    output logic                       rd_busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    assign rd_busy    = mem.rd_req_mem;
    assign rd_data    = mem.data_mem;
    // A strobe while no request is outstanding never counts as a response.
    assign rd_done    = mem.rd_req_mem && mem.mapped_data_valid;
    assign rd_timeout = mem.rd_req_mem && !mem.mapped_data_valid &&
                        (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mem.rd_req_mem  <= 1'b0;
            mem.address_mem <= RESET_ADDR;
            wait_cnt        <= '0;
        end else if (!mem.rd_req_mem) begin
            wait_cnt <= '0;
            if (rd_start) begin
                mem.rd_req_mem  <= 1'b1;
                mem.address_mem <= rd_addr;
            end
        end else if (rd_done || rd_timeout) begin
            mem.rd_req_mem <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_config_loader.sv
// Polls the FPU start register, fetches and validates the frame configuration
// (dims, addresses, KERNEL_DIM x KERNEL_DIM filter) and holds it for the controller.
module fpu_config_loader
    import fpu_cfg_pkg::*;
#(
    parameter int          KERNEL_DIM = 3,
    parameter int          MAX_WIDTH  = 1920,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
    parameter int          POLL_GAP   = 8,
    parameter int          TIMEOUT    = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    fpu_config_loader_if.master      mem,
    input  logic                     frame_done,
    output logic [15:0]              image_width,
    output logic [15:0]              image_height,
    output logic [31:0]              start_address,
    output logic [31:0]              result_address,
    output logic signed [7:0]        filter [KERNEL_DIM*KERNEL_DIM],
    output logic                     load_config_done,
    output logic                     config_valid,
    output logic                     cfg_error,
    output logic [1:0]               err_code
);

    localparam int KK        = KERNEL_DIM * KERNEL_DIM;
    localparam int NWORDS    = filter_word_count(KERNEL_DIM);
    localparam int LAST_WORD = 3 + NWORDS - 1;
    localparam int WCW       = 6;
    localparam int GW        = $clog2(POLL_GAP + 1);

    state_e          state_q, state_d;
    logic [WCW-1:0]  word_cnt;
    logic [WCW-1:0]  fword;
    logic [GW-1:0]   gap_cnt;
    logic            rd_start;
    logic [31:0]     rd_addr;
    logic [31:0]     word_addr;
    logic [31:0]     rd_data;
    logic            rd_done;
    logic            rd_timeout;
    logic            rd_busy;
    logic            dim_zero;
    logic            too_wide;

    fpu_mmio_reader #(
        .RESET_ADDR (MMIO_BASE + OFF_STARTSIG),
        .TIMEOUT    (TIMEOUT)
    ) u_reader (
        .clk        (clk),
        .rst        (rst),
        .rd_start   (rd_start),
        .rd_addr    (rd_addr),
        .mem        (mem),
        .rd_data    (rd_data),
        .rd_done    (rd_done),
        .rd_timeout (rd_timeout),
        .rd_busy    (rd_busy)
    );

    // Word sequence: DIMS, START, RESULT, then the filter words in order.
    assign fword = word_cnt - WCW'(3);

    always_comb begin
        case (word_cnt)
            WCW'(0): word_addr = MMIO_BASE + OFF_DIMS;
            WCW'(1): word_addr = MMIO_BASE + OFF_START;
            WCW'(2): word_addr = MMIO_BASE + OFF_RESULT;
            default: word_addr = MMIO_BASE + OFF_FILTER + {24'd0, fword, 2'b00};
        endcase
    end

    assign dim_zero = (image_width == 16'd0) || (image_height == 16'd0);
    assign too_wide = {16'd0, image_width} > 32'(MAX_WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_start = 1'b0;
        rd_addr  = MMIO_BASE + OFF_STARTSIG;
        case (state_q)
            ST_IDLE: begin
                rd_start = !rd_busy;
                if (rd_done) state_d = rd_data[0] ? ST_LOAD : ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GW'(POLL_GAP - 1)) state_d = ST_IDLE;
            end
            ST_LOAD: begin
                rd_start = !rd_busy;
                rd_addr  = word_addr;
                if (rd_done && word_cnt == WCW'(LAST_WORD)) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = (dim_zero || too_wide) ? ST_RELEASE : ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (frame_done) state_d = ST_RELEASE;
            end
            // Start must be seen low before the loader re-arms.
            ST_RELEASE: begin
                rd_start = !rd_busy;
                if (rd_done) state_d = rd_data[0] ? ST_REL_GAP : ST_IDLE;
            end
            ST_REL_GAP: begin
                if (gap_cnt == GW'(POLL_GAP - 1)) state_d = ST_RELEASE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rd_timeout) state_d = ST_RELEASE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state_q != ST_LOAD) word_cnt <= '0;
            else if (rd_done)       word_cnt <= word_cnt + 1'b1;
            gap_cnt <= (state_q == ST_GAP || state_q == ST_REL_GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            image_width      <= '0;
            image_height     <= '0;
            start_address    <= '0;
            result_address   <= '0;
            load_config_done <= 1'b0;
            config_valid     <= 1'b0;
            cfg_error        <= 1'b0;
            err_code         <= ERR_NONE;
            for (int i = 0; i < KK; i++) filter[i] <= '0;
        end else begin
            load_config_done <= 1'b0;
            cfg_error        <= 1'b0;
            if (state_q == ST_IDLE && rd_done && rd_data[0]) err_code <= ERR_NONE;
            if (state_q == ST_LOAD && rd_done) begin
                case (word_cnt)
                    WCW'(0): {image_width, image_height} <= rd_data;
                    WCW'(1): start_address  <= rd_data;
                    WCW'(2): result_address <= rd_data;
                    default: begin
                        // Byte lanes beyond the last coefficient fall outside the loop.
                        for (int i = 0; i < KK; i++) begin
                            if (WCW'(i / 4) == fword) filter[i] <= $signed(rd_data[31 - 8 * (i % 4) -: 8]);
                        end
                    end
                endcase
            end
            if (state_q == ST_CHECK) begin
                if (dim_zero) begin
                    err_code  <= ERR_ZERO_DIM;
                    cfg_error <= 1'b1;
                end else if (too_wide) begin
                    err_code  <= ERR_WIDTH;
                    cfg_error <= 1'b1;
                end else begin
                    load_config_done <= 1'b1;
                    config_valid     <= 1'b1;
                end
            end
            if (state_q == ST_ACTIVE && frame_done) config_valid <= 1'b0;
            if (rd_timeout) begin
                err_code  <= ERR_TIMEOUT;
                cfg_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_config_loader.sv
// Directed bench for fpu_config_loader: a K=3 and a K=5 instance, each behind
// a small register-window responder.
module tb_fpu_config_loader;

    localparam int          PG   = 4;
    localparam int          TO   = 64;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_config_loader_if bus3 ();
    fpu_config_loader_if bus5 ();

    logic [15:0]       w3, h3, w5, h5;
    logic [31:0]       sa3, ra3, sa5, ra5;
    logic signed [7:0] f3 [9];
    logic signed [7:0] f5 [25];
    logic              done3, valid3, err3, done5, valid5, err5;
    logic [1:0]        ec3, ec5;
    logic              fd3 = 1'b0;
    logic              fd5 = 1'b0;

    fpu_config_loader #(.KERNEL_DIM(3), .MAX_WIDTH(1920), .MMIO_BASE(BASE), .POLL_GAP(PG), .TIMEOUT(TO)) dut3 (
        .clk(clk), .rst(rst), .mem(bus3), .frame_done(fd3),
        .image_width(w3), .image_height(h3), .start_address(sa3), .result_address(ra3),
        .filter(f3), .load_config_done(done3), .config_valid(valid3), .cfg_error(err3), .err_code(ec3));

    fpu_config_loader #(.KERNEL_DIM(5), .MAX_WIDTH(1920), .MMIO_BASE(BASE), .POLL_GAP(PG), .TIMEOUT(TO)) dut5 (
        .clk(clk), .rst(rst), .mem(bus5), .frame_done(fd5),
        .image_width(w5), .image_height(h5), .start_address(sa5), .result_address(ra5),
        .filter(f5), .load_config_done(done5), .config_valid(valid5), .cfg_error(err5), .err_code(ec5));

    logic [31:0] m3 [0:72];
    logic [31:0] m5 [0:72];

    int n_cmp = 0;
    int n_fail = 0;

    // K=3 responder: random latency, optional withheld address, late strobe after a withheld read.
    int          wait3, lat3, issue3, last_filt3, polls3, loads3;
    bit          busy3, held3, withhold3;
    logic [31:0] wh_addr3;
    initial begin
        bus3.mapped_data_valid = 1'b0;
        bus3.data_mem = '0;
        forever begin
            @(negedge clk);
            bus3.mapped_data_valid = 1'b0;
            if (bus3.rd_req_mem === 1'b1) begin
                if (!busy3) begin
                    busy3  = 1'b1;
                    wait3  = 0;
                    lat3   = $urandom_range(2, 10);
                    issue3 = cyc;
                    held3  = withhold3 && (bus3.address_mem == wh_addr3);
                end
                wait3++;
                if (!held3 && wait3 >= lat3) begin
                    bus3.mapped_data_valid = 1'b1;
                    bus3.data_mem = m3[(bus3.address_mem - BASE) >> 2];
                    if (bus3.address_mem == BASE + 32'h120) polls3++;
                    else loads3++;
                    if (bus3.address_mem == BASE + 32'h48) last_filt3 = cyc;
                end
            end else begin
                if (busy3 && held3) begin
                    bus3.mapped_data_valid = 1'b1;
                    bus3.data_mem = 32'hFFFF_FFFF;
                end
                busy3 = 1'b0;
                held3 = 1'b0;
            end
        end
    end

    // K=5 responder: fixed latency 3, logs every non-start-register address it answers.
    int          wait5;
    logic [31:0] addr5 [$];
    initial begin
        bus5.mapped_data_valid = 1'b0;
        bus5.data_mem = '0;
        forever begin
            @(negedge clk);
            bus5.mapped_data_valid = 1'b0;
            if (bus5.rd_req_mem === 1'b1) begin
                wait5++;
                if (wait5 == 3) begin
                    bus5.mapped_data_valid = 1'b1;
                    bus5.data_mem = m5[(bus5.address_mem - BASE) >> 2];
                    if (bus5.address_mem != BASE + 32'h120) addr5.push_back(bus5.address_mem);
                end
            end else begin
                wait5 = 0;
            end
        end
    end

    int ndone3, nerr3, done_cyc3, err_cyc3, ndone5;
    initial forever begin
        @(negedge clk);
        if (done3 === 1'b1) begin ndone3++; done_cyc3 = cyc; end
        if (err3 === 1'b1)  begin nerr3++;  err_cyc3  = cyc; end
        if (done5 === 1'b1) ndone5++;
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait3_result(input int base);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step(1);
            if (ndone3 + nerr3 != base) seen = 1'b1;
        end
        chk("dut3 result arrives", seen, 1'b1);
    endtask

    function automatic logic [255:0] pack3();
        logic [255:0] p = '0;
        for (int i = 0; i < 9; i++) p = {p[247:0], f3[i]};
        return p;
    endfunction

    function automatic logic [255:0] pack5();
        logic [255:0] p = '0;
        for (int i = 0; i < 25; i++) p = {p[247:0], f5[i]};
        return p;
    endfunction

    typedef struct {
        logic [31:0] dims, sa, ra, w0, w1, w2;
        logic [1:0]  ec;
        logic [71:0] fexp;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] exp5 [10];
    int          bd, be, p0, l0;
    logic        ok_vec;

    initial begin
        vecs[0] = '{32'h00A0_0005, 32'h0000_0000, 32'h0000_1430, 32'h01FF_0001, 32'hFF00_0100, 32'h01AA_BBCC, 2'd0, 72'h01_FF_00_01_FF_00_01_00_01};
        vecs[1] = '{32'h0780_0438, 32'h2000_0000, 32'h3000_0000, 32'h7F80_FE02, 32'h1020_3040, 32'h9C12_3456, 2'd0, 72'h7F_80_FE_02_10_20_30_40_9C};
        vecs[2] = '{32'h0000_0258, 32'h0000_0100, 32'h0000_0200, 32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 2'd2, 72'h11_22_33_44_55_66_77_88_99};
        vecs[3] = '{32'h07D0_000A, 32'h0000_0300, 32'h0000_0400, 32'hF0E0_D0C0, 32'hB0A0_9080, 32'h7000_0000, 2'd3, 72'hF0_E0_D0_C0_B0_A0_90_80_70};
        vecs[4] = '{32'h0781_0001, 32'h0000_0500, 32'h0000_0600, 32'h0000_0000, 32'h0000_0000, 32'h05FF_FFFF, 2'd3, 72'h00_00_00_00_00_00_00_00_05};
        vecs[5] = '{32'h0005_0000, 32'h0000_0700, 32'h0000_0800, 32'h0102_0304, 32'h0506_0708, 32'h0900_0000, 2'd2, 72'h01_02_03_04_05_06_07_08_09};
        exp5 = '{BASE, BASE + 32'h20, BASE + 32'h100, BASE + 32'h40, BASE + 32'h44,
                 BASE + 32'h48, BASE + 32'h4C, BASE + 32'h50, BASE + 32'h54, BASE + 32'h58};
        for (int i = 0; i < 73; i++) begin m3[i] = '0; m5[i] = '0; end

        step(3);
        chk("reset addr", bus3.address_mem, BASE + 32'h120);
        chk("reset rd_req", bus3.rd_req_mem, 1'b0);
        chk("reset outputs", {w3, h3, sa3, ra3, done3, valid3, err3, ec3}, '0);
        chk("reset filter", pack3(), '0);
        rst = 1'b0;

        // K=5: 25 coefficients over 7 words, low bytes of the last word unused.
        m5[0] = 32'h0040_0030; m5[8] = 32'hABCD_0000; m5[64] = 32'h1234_5678;
        for (int n = 0; n < 6; n++) m5[16 + n] = {8'(4 * n), 8'(4 * n + 1), 8'(4 * n + 2), 8'(4 * n + 3)};
        m5[22] = 32'h18AA_BBCC;
        m5[72] = 32'h1;
        for (int i = 0; i < 400 && ndone5 == 0; i++) step(1);
        chk("k5 done", ndone5, 1);
        chk("k5 valid", valid5, 1'b1);
        chk("k5 dims", {w5, h5}, 32'h0040_0030);
        chk("k5 filter", pack5(), 200'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18);
        chk("k5 read count", addr5.size(), 10);
        for (int i = 0; i < 10; i++)
            chk("k5 read addr", (i < addr5.size()) ? addr5[i] : 32'hDEAD_DEAD, exp5[i]);

        for (int v = 0; v < 6; v++) begin
            m3[0] = vecs[v].dims; m3[8] = vecs[v].sa; m3[64] = vecs[v].ra;
            m3[16] = vecs[v].w0;  m3[17] = vecs[v].w1; m3[18] = vecs[v].w2;
            ok_vec = (vecs[v].ec == 2'd0);
            bd = ndone3; be = nerr3;
            m3[72] = 32'h1;
            wait3_result(bd + be);
            chk("done pulses", ndone3 - bd, ok_vec ? 1 : 0);
            chk("error pulses", nerr3 - be, ok_vec ? 0 : 1);
            chk("result latency", (ok_vec ? done_cyc3 : err_cyc3) - last_filt3, 2);
            chk("err_code", ec3, vecs[v].ec);
            chk("config_valid", valid3, ok_vec);
            chk("dims", {w3, h3}, vecs[v].dims);
            chk("addresses", {sa3, ra3}, {vecs[v].sa, vecs[v].ra});
            chk("filter", pack3(), vecs[v].fexp);
            step(1);
            chk("pulse width", {done3, err3}, 2'b00);
            p0 = polls3; l0 = loads3;
            step(40);
            chk("held start no reload", {ndone3 - bd, nerr3 - be, loads3 - l0}, {ok_vec ? 32'd1 : 32'd0, ok_vec ? 32'd0 : 32'd1, 32'd0});
            chk("reads while held", (polls3 - p0) > 0, !ok_vec);
            if (ok_vec) begin
                fd3 = 1'b1;
                step(1);
                fd3 = 1'b0;
                chk("frame_done clears valid", valid3, 1'b0);
                p0 = polls3;
                step(40);
                chk("release polls", (polls3 - p0) >= 2, 1'b1);
                chk("release no reload", {loads3 - l0, ndone3 - bd}, {32'd0, 32'd1});
            end
            m3[72] = 32'h0;
            step(60);
        end

        // START read withheld: timeout, then a late strobe with no request outstanding.
        m3[0] = vecs[0].dims;
        withhold3 = 1'b1; wh_addr3 = BASE + 32'h20;
        bd = ndone3; be = nerr3;
        m3[72] = 32'h1;
        wait3_result(bd + be);
        chk("timeout cycle", err_cyc3 - issue3, TO);
        chk("timeout err_code", ec3, 2'd1);
        chk("timeout no done", {ndone3 - bd, valid3}, {32'd0, 1'b0});
        withhold3 = 1'b0;
        step(30);
        chk("timeout held state", {ec3, valid3, nerr3 - be, ndone3 - bd}, {2'd1, 1'b0, 32'd1, 32'd0});
        m3[72] = 32'h0;
        step(60);

        // New load clears err_code; reset mid-load zeroes everything.
        l0 = loads3;
        m3[72] = 32'h1;
        for (int i = 0; i < 200 && loads3 == l0; i++) step(1);
        chk("load started", loads3 > l0, 1'b1);
        chk("err cleared on load", ec3, 2'd0);
        rst = 1'b1;
        m3[72] = 32'h0;
        step(1);
        chk("mid-load reset outputs", {w3, h3, sa3, ra3, done3, valid3, err3, ec3}, '0);
        chk("mid-load reset filter", pack3(), '0);
        chk("mid-load reset bus", {bus3.rd_req_mem, bus3.address_mem}, {1'b0, BASE + 32'h120});
        rst = 1'b0;
        step(40);
        chk("after reset idle", {ndone3 - bd, valid3}, {32'd0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_config_loader.md
Name: fpu_config_loader

Overview:
Parametrised successor to the FPU's fixed 3x3 configuration loader. Polls the memory-mapped start signal and fetches image dims, source/result addresses and a KERNEL_DIM x KERNEL_DIM signed filter over the mapped-memory read handshake. Validates the fetched configuration and presents it to the FPU controller. Adds timeout detection, dimension checking, start-release re-arming and a frame_done return path.

Parameters:
KERNEL_DIM, 3, filter side length; legal values 3, 5, 7.
MAX_WIDTH, 1920, largest legal image_width in pixels.
MMIO_BASE, 32'h1000_0000, base of the FPU register window.
POLL_GAP, 8, idle cycles between start-signal polls (>=1).
TIMEOUT, 1024, cycles to wait for mapped_data_valid before error.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
address_mem  out  32  mapped read address.
rd_req_mem  out  1  read request; level, held until response.
data_mem  in  32  read data, valid when mapped_data_valid=1.
mapped_data_valid  in  1  one-cycle read-response strobe.
frame_done  in  1  pulse from controller: current frame finished.
image_width  out  16  captured width.
image_height  out  16  captured height.
start_address  out  32  captured source address.
result_address  out  32  captured destination address.
filter  out  KERNEL_DIM*KERNEL_DIM x 8 signed  coefficients, row-major.
load_config_done  out  1  one-cycle pulse: valid config loaded.
config_valid  out  1  level: config outputs valid.
cfg_error  out  1  one-cycle pulse on failed load.
err_code  out  2  0 none, 1 timeout, 2 zero dim, 3 width>MAX_WIDTH; holds until next load starts.

Behaviour:
- Reset: all outputs 0, filter all 0, address_mem=MMIO_BASE+0x120, state IDLE; reset mid-read abandons the read, and any late mapped_data_valid is ignored.
- Offsets: DIMS 0x000 (width[31:16], height[15:0]); START 0x020; FILTER 0x040 + 4n, n = 0 .. ceil(K*K/4)-1; RESULT 0x100; STARTSIG 0x120 (bit 0).
- Filter word n: byte[31:24] -> filter[4n], [23:16] -> 4n+1, [15:8] -> 4n+2, [7:0] -> 4n+3. Bytes past K*K-1 are ignored.
- Read handshake: address_mem stable and rd_req_mem=1 from the issue cycle until the cycle mapped_data_valid=1. Data is captured that cycle. rd_req_mem=0 the following cycle, and the next read issues one cycle after that.
- A valid strobe with rd_req_mem=0 is ignored.
- Timeout: TIMEOUT cycles with rd_req_mem=1 and no valid -> err_code=1, cfg_error pulse, go to RELEASE.
- FSM:
  - IDLE: issue STARTSIG read. bit0=1 -> LOAD; bit0=0 -> GAP.
  - GAP: wait POLL_GAP cycles -> IDLE.
  - LOAD: sequential reads DIMS, START, RESULT, FILTER[0..N-1], using a word counter.
  - CHECK: one cycle. height=0 or width=0 -> err 2; width>MAX_WIDTH -> err 3; else OK.
  - OK path: load_config_done=1 and config_valid=1 in the cycle after CHECK -> ACTIVE.
  - Error path: cfg_error=1 in the cycle after CHECK, config_valid stays 0 -> RELEASE.
  - ACTIVE: ignore MMIO. frame_done -> config_valid=0 -> RELEASE.
  - RELEASE: poll STARTSIG every POLL_GAP cycles until bit0=0, then -> IDLE. A held start does not retrigger.
- frame_done outside ACTIVE is ignored.
- Captured outputs update only on their own capture cycle and hold between loads.
- err_code clears to 0 on entry to LOAD.
- Latency: final filter word captured at cycle T -> CHECK at T+1 -> load_config_done at T+2.

Decomposition:
- Package fpu_cfg_pkg: register offsets, state enum, err_code constants, filter_word_count(K) function.
- Sub-module fpu_mmio_reader: one read handshake plus timeout counter; outputs rd_data, rd_done, rd_timeout.

Test Plan:
- K=3, dims {160,5}, start 0, result 5168, filter words 0x01FF0001 / 0xFF000100 / 0x01xxxxxx, responder latency 2..10 random -> filter = {1,-1,0,1,-1,0,1,0,1}, load_config_done one pulse at CHECK+1, config_valid=1.
- K=5, filter bytes 0..24 -> 7 FILTER reads at 0x1000_0040..0x1000_0058, filter[24]=24, word-6 bytes [23:0] ignored.
- dims {0,600} -> err_code=2, one cfg_error pulse, no load_config_done. Start held high -> no reload. Drop start then raise again -> new load begins.
- dims {2000,10} with MAX_WIDTH=1920 -> err_code=3, config_valid=0.
- Responder withholds valid on START read for TIMEOUT cycles -> cfg_error at cycle TIMEOUT, err_code=1. Late valid afterwards is ignored.
- In ACTIVE, pulse frame_done -> config_valid=0 next cycle. Start still 1 -> loader stays in RELEASE polling every POLL_GAP+handshake cycles. Assert rst mid-LOAD -> all outputs 0 next cycle.
